// File: rtl/jt51_sh_ram.sv
// jt51_sh_ram
// Parametrised delay line for the time-multiplexed operator/channel pipeline.
// Each asserted cen is one pipeline slot. A value written on din comes back
// out on drop exactly STAGES cen-cycles later, so it stays aligned with its
// own slot. The line is a circular buffer: a write pointer walks over a plain
// memory array, which lets deep or wide delays map to RAM instead of flops.
// A per-stage valid mask makes unwritten or flushed stages read as RSTVAL.
// Without the mask, reset would leave stale RAM contents visible.
//
// Parameters:
//   WIDTH   data bits per stage
//   STAGES  delay depth in cen cycles (>= 2, any integer)
//   RSTVAL  bit value every output bit shows for an unwritten/flushed stage
//   AW      derived pointer/tap-select width, clog2(STAGES)
//
// Ports:
//   rst      in   async reset, active-high
//   clk      in   clock
//   cen      in   clock enable, one slot per asserted cycle
//   clr      in   synchronous flush (clears valid mask, pointer to 0)
//   din      in   data written this slot
//   drop     out  data written STAGES cen-cycles ago
//   tap_sel  in   tap offset k, 0..STAGES-1
//   tap      out  data written k+1 cen-cycles ago
//   slot     out  current write pointer
//
// Optional feature: define JT51_SH_TAP_EN to build the mid-line tap read port.
// When it is not defined, tap is tied to the RSTVAL pattern and tap_sel is
// ignored.

module jt51_sh_ram #(
   parameter int   WIDTH  = 14,
   parameter int   STAGES = 32,
   parameter logic RSTVAL = 1'b0,
   localparam int  AW     = $clog2(STAGES)
) (
   input  logic             rst,
   input  logic             clk,
   input  logic             cen,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] drop,
   input  logic [AW-1:0]    tap_sel,
   output logic [WIDTH-1:0] tap,
   output logic [AW-1:0]    slot
);

   logic [WIDTH-1:0]  mem [STAGES];
   logic [STAGES-1:0] valid;
   logic [AW-1:0]     ptr;
   logic [AW-1:0]     ptr_next;

   // The pointer wraps explicitly at STAGES-1. STAGES need not be a power of
   // two, so letting the counter overflow would visit unused slots.
   always_comb begin
      ptr_next = ptr + AW'(1);
      if (ptr == AW'(STAGES - 1)) begin
         ptr_next = '0;
      end
   end

   // Pointer and valid mask hold the only reset state. A flush wins over a
   // write in the same cycle, so the pointer restarts at 0 and not at 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
         ptr   <= '0;
      end else if (clr) begin
         valid <= '0;
         ptr   <= '0;
      end else if (cen) begin
         valid[ptr] <= 1'b1;
         ptr        <= ptr_next;
      end
   end

   // The storage array has no reset, so it can be inferred as RAM. A flushed
   // cycle writes nothing; the cleared valid bit already hides old data.
   always_ff @(posedge clk) begin
      if (cen && !clr) begin
         mem[ptr] <= din;
      end
   end

   // The slot under the pointer is about to be overwritten, so its current
   // contents are the oldest entry in the line.
   assign drop = valid[ptr] ? mem[ptr] : {WIDTH{RSTVAL}};
   assign slot = ptr;

`ifdef JT51_SH_TAP_EN
   logic [AW:0]   tap_sum;
   logic [AW-1:0] tap_idx;
   logic          tap_range;

   // The tap index is (ptr - 1 - tap_sel) mod STAGES. STAGES is added before
   // the subtraction so the sum never goes negative, and it is folded back
   // once at most. Offsets past the end of a non-power-of-two line are
   // reported as unwritten.
   always_comb begin
      tap_sum = {1'b0, ptr} + (AW+1)'(STAGES - 1) - {1'b0, tap_sel};
      if (tap_sum >= (AW+1)'(STAGES)) begin
         tap_sum = tap_sum - (AW+1)'(STAGES);
      end
      tap_idx   = tap_sum[AW-1:0];
      tap_range = ({1'b0, tap_sel} < (AW+1)'(STAGES));
   end

   assign tap = (tap_range && valid[tap_idx]) ? mem[tap_idx] : {WIDTH{RSTVAL}};
`else
   logic unused_tap_sel;

   assign unused_tap_sel = ^tap_sel;
   assign tap            = {WIDTH{RSTVAL}};
`endif

endmodule

// File: tb/tb_jt51_sh_ram.sv
// tb_jt51_sh_ram
// Directed bench for the jt51_sh_ram delay line. It uses two instances:
//   a_*: WIDTH=14, STAGES=32, RSTVAL=0
//   b_*: WIDTH=14, STAGES=5,  RSTVAL=1 (non-power-of-two depth)
// Expected tap values depend on whether JT51_SH_TAP_EN is defined.

module tb_jt51_sh_ram;

`ifdef JT51_SH_TAP_EN
   localparam bit TAP_EN = 1'b1;
`else
   localparam bit TAP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;

   logic        a_cen, a_clr;
   logic [13:0] a_din, a_drop, a_tap;
   logic [4:0]  a_tap_sel, a_slot;

   logic        b_cen, b_clr;
   logic [13:0] b_din, b_drop, b_tap;
   logic [2:0]  b_tap_sel, b_slot;

   int vectors     = 0;
   int miscompares = 0;

   logic [13:0] model [32];
   logic [13:0] exp_v;

   always #5 clk = ~clk;

   jt51_sh_ram #(.WIDTH(14), .STAGES(32), .RSTVAL(1'b0)) dut_a (
      .rst(rst), .clk(clk), .cen(a_cen), .clr(a_clr), .din(a_din),
      .drop(a_drop), .tap_sel(a_tap_sel), .tap(a_tap), .slot(a_slot)
   );

   jt51_sh_ram #(.WIDTH(14), .STAGES(5), .RSTVAL(1'b1)) dut_b (
      .rst(rst), .clk(clk), .cen(b_cen), .clr(b_clr), .din(b_din),
      .drop(b_drop), .tap_sel(b_tap_sel), .tap(b_tap), .slot(b_slot)
   );

   // One rising edge, then settle 1 time unit past it.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Count one comparison and report it if it fails.
   task automatic checkOutput(input string tag, input logic [13:0] obs, input logic [13:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Value stream fed to instance b: 0x0055 first, then the cycle number.
   function automatic logic [13:0] bval(input int k);
      return (k == 0) ? 14'h0055 : 14'(k);
   endfunction

   initial begin
      rst = 1'b1;
      a_cen = 1'b0; a_clr = 1'b0; a_din = '0; a_tap_sel = 5'd7;
      b_cen = 1'b0; b_clr = 1'b0; b_din = '0; b_tap_sel = 3'd6;
      foreach (model[i]) model[i] = '0;

      // Reset state on both instances
      #3;
      checkOutput("rst a_drop", a_drop, 14'h0000);
      checkOutput("rst a_tap",  a_tap,  14'h0000);
      checkOutput("rst a_slot", {9'd0, a_slot}, 14'd0);
      checkOutput("rst b_drop", b_drop, 14'h3FFF);
      checkOutput("rst b_tap",  b_tap,  14'h3FFF);
      checkOutput("rst b_slot", {11'd0, b_slot}, 14'd0);
      applyStimulus();
      rst = 1'b0;
      b_tap_sel = 3'd2;

      // cen always high. a gets din=slot+1; b gets 0x55 first, then n.
      // On a, tap_sel=7 reads RSTVAL until 8 writes have happened.
      for (int n = 0; n < 49; n++) begin
         a_cen = 1'b1; a_din = 14'((n % 32) + 1);
         b_cen = 1'b1; b_din = bval(n);
         #1;
         checkOutput("seq a_drop", a_drop, (n < 32) ? 14'd0 : 14'(((n - 32) % 32) + 1));
         checkOutput("seq a_slot", {9'd0, a_slot}, 14'(n % 32));
         checkOutput("seq a_tap7", a_tap, (TAP_EN && n >= 8) ? 14'(((n - 8) % 32) + 1) : 14'd0);
         checkOutput("seq b_drop", b_drop, (n < 5) ? 14'h3FFF : bval(n - 5));
         checkOutput("seq b_slot", {11'd0, b_slot}, 14'(n % 5));
         checkOutput("seq b_tap2", b_tap, (TAP_EN && n >= 3) ? bval(n - 3) : 14'h3FFF);
         applyStimulus();
      end

      // b is full; an offset past its 5-stage depth still reads as RSTVAL
      b_tap_sel = 3'd6;
      #1;
      checkOutput("b_tap out of range", b_tap, 14'h3FFF);

      // Async reset mid-sweep (a at slot 17) with cen low, between clock edges
      a_cen = 1'b0; b_cen = 1'b0;
      checkOutput("pre-reset a_slot", {9'd0, a_slot}, 14'd17);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async a_drop", a_drop, 14'h0000);
      checkOutput("async a_tap",  a_tap,  14'h0000);
      checkOutput("async a_slot", {9'd0, a_slot}, 14'd0);
      checkOutput("async b_drop", b_drop, 14'h3FFF);
      #1;
      rst = 1'b0;
      applyStimulus();

      // Random cen/din/tap_sel against a 32-stage flop shift-register model
      for (int n = 0; n < 2000; n++) begin
         a_cen     = ($urandom_range(3) != 0);
         a_din     = 14'($urandom);
         a_tap_sel = 5'($urandom_range(31));
         #1;
         checkOutput("rand a_drop", a_drop, model[31]);
         checkOutput("rand a_tap", a_tap, TAP_EN ? model[a_tap_sel] : 14'd0);
         if (a_cen) begin
            for (int i = 31; i > 0; i--) model[i] = model[i - 1];
            model[0] = a_din;
         end
         applyStimulus();
      end

      // Flush: fill every slot, then clr together with cen and din=0x1234
      a_tap_sel = 5'd31;
      for (int i = 0; i < 32; i++) begin
         a_cen = 1'b1; a_din = 14'(100 + i);
         applyStimulus();
      end
      a_clr = 1'b1; a_din = 14'h1234;
      applyStimulus();
      a_clr = 1'b0;
      a_din = 14'h0777;
      for (int i = 0; i < 32; i++) begin
         #1;
         checkOutput("flush a_drop", a_drop, 14'h0000);
         checkOutput("flush a_slot", {9'd0, a_slot}, 14'(i));
         checkOutput("flush a_tap31", a_tap, 14'h0000);
         applyStimulus();
      end
      checkOutput("post-flush a_drop", a_drop, 14'h0777);

      // Flush with cen low on b: still clears the line and the pointer
      b_cen = 1'b1; b_din = 14'h0042;
      applyStimulus();
      applyStimulus();
      exp_v = 14'h3FFF;
      b_cen = 1'b0; b_clr = 1'b1;
      applyStimulus();
      b_clr = 1'b0;
      checkOutput("clr nocen b_slot", {11'd0, b_slot}, 14'd0);
      checkOutput("clr nocen b_drop", b_drop, exp_v);
      b_cen = 1'b1;
      for (int i = 0; i < 5; i++) applyStimulus();
      checkOutput("clr nocen b_drop after 5", b_drop, 14'h0042);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
